// File: rtl/mips_ram_pkg.sv
// Shared types and helpers for the MIPS testbench RAM models.
// Contents: word/byte-enable typedefs, FSM state enum, byte swap and
// arithmetic-series preload helpers.
package mips_ram_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned LANES  = 4;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [LANES-1:0]  be_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } ram_state_t;

    // Reverse byte order of a 32-bit word.
    function automatic word_t bswap32(input word_t w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Word i of the preload series: base + step*i (mod 2^32), optionally byte-reversed.
    function automatic word_t preload_word(input word_t base, input word_t step,
                                           input int unsigned i, input bit swap);
        word_t v;
        v = base + step * 32'(i);
        return swap ? bswap32(v) : v;
    endfunction

endpackage

// File: rtl/dram_ws_param_if.sv
// Data-side memory bus between a CPU core and the data RAM.
// Signals: data_address(32), data_write, data_read, data_writedata(32),
// data_byteenable(4) from master; data_waitrequest, data_readdata(32),
// data_err from slave.
interface dram_ws_param_if;
    import mips_ram_pkg::*;

    logic  [31:0] data_address;
    logic         data_write;
    logic         data_read;
    word_t        data_writedata;
    be_t          data_byteenable;
    logic         data_waitrequest;
    word_t        data_readdata;
    logic         data_err;

    modport master (
        output data_address, data_write, data_read, data_writedata, data_byteenable,
        input  data_waitrequest, data_readdata, data_err
    );

    modport slave (
        input  data_address, data_write, data_read, data_writedata, data_byteenable,
        output data_waitrequest, data_readdata, data_err
    );

endinterface

// File: rtl/ram_lane_merge.sv
// Byte-lane merge: enabled lanes take the new word, others keep the old word.
// Ports: old_word(32) in, new_word(32) in, be(4) in, merged_c(32) out (combinational).
module ram_lane_merge
    import mips_ram_pkg::*;
(
    input  word_t old_word,
    input  word_t new_word,
    input  be_t   be,
    output word_t merged_c
);

    always_comb begin
        merged_c = old_word;
        for (int n = 0; n < int'(LANES); n++) begin
            if (be[n]) begin
                merged_c[8*n +: 8] = new_word[8*n +: 8];
            end
        end
    end

endmodule

// File: rtl/dram_ws_param.sv
// Parametrised data RAM for MIPS CPU testbenches with byte enables,
// configurable wait states, bounds checking and an arithmetic-series preload.
// Ports: clk, reset (sync, active-high), bus (dram_ws_param_if.slave):
//   data_address/read/write/writedata/byteenable in;
//   data_waitrequest, data_readdata (combinational in the completion cycle),
//   data_err (sticky) out.
module dram_ws_param
    import mips_ram_pkg::*;
#(
    parameter int unsigned DEPTH       = 4096,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter int unsigned INIT_WORDS  = 15,
    parameter word_t       INIT_BASE   = 32'h12345678,
    parameter word_t       INIT_STEP   = 32'hdcba1234,
    parameter bit          BYTE_SWAP   = 1'b1
)
(
    input logic            clk,
    input logic            reset,
    dram_ws_param_if.slave bus
);

    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES);
    localparam bit          NO_WAIT   = (WAIT_CYCLES == 0);

    ram_state_t    state;
    logic [3:0]    cnt;
    logic          err_q;
    word_t         hold_q;
    word_t         mem [DEPTH];

    logic          req;
    logic          at_last;
    logic          waitreq;
    logic          complete;
    logic          in_range;
    logic          rw_both;
    logic          rd_fire;
    logic          wr_fire;
    logic [AW-1:0] idx;
    word_t         mem_word;
    word_t         rd_word;
    word_t         merged;
    logic          unused_addr_lsb;

    assign unused_addr_lsb = ^bus.data_address[1:0];

    assign req      = bus.data_read | bus.data_write;
    assign idx      = bus.data_address[AW+1:2];
    assign in_range = {2'b00, bus.data_address[31:2]} < 32'(DEPTH);
    assign rw_both  = bus.data_read & bus.data_write;

    // While reset is high the FSM is treated as IDLE, so a BUSY access cannot complete.
    assign at_last  = !reset && (state == BUSY) && (cnt == WAIT_LAST);
    assign waitreq  = req && !(NO_WAIT || at_last);
    assign complete = req && !waitreq;

    // Read+write together behaves as a write; readdata is left untouched.
    assign rd_fire  = complete && bus.data_read && !bus.data_write;
    assign wr_fire  = complete && bus.data_write && in_range && !reset;

    assign mem_word = mem[idx];
    assign rd_word  = in_range ? mem_word : '0;

    ram_lane_merge u_merge (
        .old_word (mem_word),
        .new_word (bus.data_writedata),
        .be       (bus.data_byteenable),
        .merged_c (merged)
    );

    // Handshake FSM, held read data and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            err_q  <= 1'b0;
            hold_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req && !NO_WAIT) begin
                        state <= BUSY;
                        cnt   <= 4'd1;
                    end
                end
                BUSY: begin
                    if (!req) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt < WAIT_LAST) begin
                        cnt <= cnt + 4'd1;
                    end else begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase

            if (rd_fire) begin
                hold_q <= rd_word;
            end
            if (complete && (!in_range || rw_both)) begin
                err_q <= 1'b1;
            end
        end
    end

    // Storage array; only enabled lanes change on a completed in-range write.
    always @(posedge clk) begin
        if (wr_fire) begin
            mem[idx] <= merged;
        end
    end

    // Time-zero image load; words past INIT_WORDS stay uninitialised.
    initial begin
        for (int unsigned i = 0; (i < INIT_WORDS) && (i < DEPTH); i++) begin
            mem[AW'(i)] <= preload_word(INIT_BASE, INIT_STEP, i, BYTE_SWAP);
        end
    end

    assign bus.data_waitrequest = waitreq;
    assign bus.data_readdata    = rd_fire ? rd_word : hold_q;
    assign bus.data_err         = err_q;

endmodule

// File: tb/tb_dram_ws_param.sv
// Self-checking bench for dram_ws_param: three instances (default timing,
// WAIT_CYCLES=3 with DEPTH=16, WAIT_CYCLES=2) driven through the data bus
// interface; expected read data goes through a scoreboard queue.
module tb_dram_ws_param;
    import mips_ram_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst3, rst2;

    dram_ws_param_if b0 ();
    dram_ws_param_if b3 ();
    dram_ws_param_if b2 ();

    dram_ws_param u0 (.clk(clk), .reset(rst0), .bus(b0));
    dram_ws_param #(.DEPTH(16), .WAIT_CYCLES(3)) u3 (.clk(clk), .reset(rst3), .bus(b3));
    dram_ws_param #(.WAIT_CYCLES(2)) u2 (.clk(clk), .reset(rst2), .bus(b2));

    int    n_cmp = 0;
    int    n_bad = 0;
    word_t exp_q [$];

    function automatic word_t pre(input int i);
        word_t v;
        v = 32'h12345678 + 32'hdcba1234 * 32'(i);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    task automatic drive(input int w, input logic rd, input logic wr,
                         input word_t a, input word_t wd, input be_t be);
        case (w)
            0: begin
                b0.data_read = rd; b0.data_write = wr; b0.data_address = a;
                b0.data_writedata = wd; b0.data_byteenable = be;
            end
            3: begin
                b3.data_read = rd; b3.data_write = wr; b3.data_address = a;
                b3.data_writedata = wd; b3.data_byteenable = be;
            end
            default: begin
                b2.data_read = rd; b2.data_write = wr; b2.data_address = a;
                b2.data_writedata = wd; b2.data_byteenable = be;
            end
        endcase
    endtask

    function automatic logic get_wait(input int w);
        return (w == 0) ? b0.data_waitrequest : (w == 3) ? b3.data_waitrequest : b2.data_waitrequest;
    endfunction

    function automatic word_t get_rd(input int w);
        return (w == 0) ? b0.data_readdata : (w == 3) ? b3.data_readdata : b2.data_readdata;
    endfunction

    function automatic logic get_err(input int w);
        return (w == 0) ? b0.data_err : (w == 3) ? b3.data_err : b2.data_err;
    endfunction

    // Drives one access (starting just after a posedge), waits for completion,
    // and returns the number of waitrequest cycles and the completion readdata.
    task automatic access(input int w, input logic rd, input logic wr, input word_t a,
                          input word_t wd, input be_t be,
                          output int nwait, output word_t rdata, output bit to);
        drive(w, rd, wr, a, wd, be);
        nwait = 0;
        to    = 1'b1;
        rdata = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (get_wait(w) == 1'b0) begin
                rdata = get_rd(w);
                to    = 1'b0;
                break;
            end
            nwait++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        drive(w, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic test_reset();
        int ws [3] = '{0, 3, 2};
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(3, 1'b0, 1'b0, '0, '0, '0);
        drive(2, 1'b0, 1'b0, '0, '0, '0);
        rst0 = 1'b1; rst3 = 1'b1; rst2 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst0 = 1'b0; rst3 = 1'b0; rst2 = 1'b0;
        @(negedge clk);
        foreach (ws[i]) begin
            n_cmp++;
            if (get_rd(ws[i]) !== 32'h0) begin
                n_bad++; $display("FAIL reset_readdata[%0d]: got %h expected 00000000", ws[i], get_rd(ws[i]));
            end
            n_cmp++;
            if (get_err(ws[i]) !== 1'b0) begin
                n_bad++; $display("FAIL reset_err[%0d]: got %b expected 0", ws[i], get_err(ws[i]));
            end
            n_cmp++;
            if (get_wait(ws[i]) !== 1'b0) begin
                n_bad++; $display("FAIL reset_wait[%0d]: got %b expected 0", ws[i], get_wait(ws[i]));
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_preload();
        word_t a_tab [4] = '{32'h0, 32'h4, 32'h8, 32'h38};
        word_t e_tab [4] = '{32'h78563412, 32'hAC68EEEE, 32'hE07AA8CB, pre(14)};
        int nw; word_t rd; bit to; word_t e;
        foreach (a_tab[i]) begin
            exp_q.push_back(e_tab[i]);
            access(0, 1'b1, 1'b0, a_tab[i], '0, '0, nw, rd, to);
            e = exp_q.pop_front();
            n_cmp++;
            if (to !== 1'b0 || nw !== 0) begin
                n_bad++; $display("FAIL preload_wait[%h]: got %0d waits (timeout %b) expected 0", a_tab[i], nw, to);
            end
            n_cmp++;
            if (rd !== e) begin
                n_bad++; $display("FAIL preload_data[%h]: got %h expected %h", a_tab[i], rd, e);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (get_rd(0) !== e_tab[3]) begin
            n_bad++; $display("FAIL preload_hold: got %h expected %h", get_rd(0), e_tab[3]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wait_states();
        int nw; word_t rd; bit to; word_t e;
        exp_q.push_back(32'hAC68EEEE);
        access(3, 1'b1, 1'b0, 32'h4, '0, '0, nw, rd, to);
        e = exp_q.pop_front();
        n_cmp++;
        if (to !== 1'b0 || nw !== 3) begin
            n_bad++; $display("FAIL wait3_count: got %0d waits (timeout %b) expected 3", nw, to);
        end
        n_cmp++;
        if (rd !== e) begin
            n_bad++; $display("FAIL wait3_data: got %h expected %h", rd, e);
        end
        // abandoned request: one cycle only
        drive(3, 1'b1, 1'b0, 32'h0, '0, '0);
        @(negedge clk);
        n_cmp++;
        if (get_wait(3) !== 1'b1 || get_rd(3) !== 32'hAC68EEEE) begin
            n_bad++; $display("FAIL abandon_first: got wait %b data %h expected wait 1 data ac68eeee", get_wait(3), get_rd(3));
        end
        @(posedge clk); #1;
        drive(3, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        n_cmp++;
        if (get_wait(3) !== 1'b0 || get_rd(3) !== 32'hAC68EEEE) begin
            n_bad++; $display("FAIL abandon_hold: got wait %b data %h expected wait 0 data ac68eeee", get_wait(3), get_rd(3));
        end
        @(posedge clk); #1;
        exp_q.push_back(32'h78563412);
        access(3, 1'b1, 1'b0, 32'h0, '0, '0, nw, rd, to);
        e = exp_q.pop_front();
        n_cmp++;
        if (to !== 1'b0 || nw !== 3) begin
            n_bad++; $display("FAIL after_abandon_count: got %0d waits (timeout %b) expected 3", nw, to);
        end
        n_cmp++;
        if (rd !== e) begin
            n_bad++; $display("FAIL after_abandon_data: got %h expected %h", rd, e);
        end
    endtask

    task automatic test_byte_enable();
        word_t a_tab [4] = '{32'h10, 32'h14, 32'h18, 32'h1C};
        word_t d_tab [4] = '{32'hAABBCCDD, 32'hFFFFFFFF, 32'h11223344, 32'hCAFEF00D};
        be_t   m_tab [4] = '{4'b0101, 4'b0000, 4'b1010, 4'b1111};
        int nw; word_t rd; bit to; word_t e; word_t p;
        foreach (a_tab[i]) begin
            access(0, 1'b0, 1'b1, a_tab[i], d_tab[i], m_tab[i], nw, rd, to);
            n_cmp++;
            if (to !== 1'b0 || nw !== 0) begin
                n_bad++; $display("FAIL be_write_wait[%h]: got %0d waits (timeout %b) expected 0", a_tab[i], nw, to);
            end
            p = pre(int'(a_tab[i] >> 2));
            e = p;
            for (int n = 0; n < 4; n++) begin
                if (m_tab[i][n]) e[8*n +: 8] = d_tab[i][8*n +: 8];
            end
            exp_q.push_back(e);
            access(0, 1'b1, 1'b0, a_tab[i], '0, '0, nw, rd, to);
            e = exp_q.pop_front();
            n_cmp++;
            if (rd !== e) begin
                n_bad++; $display("FAIL be_read[%h]: got %h expected %h", a_tab[i], rd, e);
            end
        end
    endtask

    task automatic test_bounds();
        int nw; word_t rd; bit to; word_t e;
        @(negedge clk);
        n_cmp++;
        if (get_err(3) !== 1'b0) begin
            n_bad++; $display("FAIL bounds_err_before: got %b expected 0", get_err(3));
        end
        @(posedge clk); #1;
        access(3, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF, nw, rd, to);
        n_cmp++;
        if (to !== 1'b0 || nw !== 3) begin
            n_bad++; $display("FAIL bounds_write_wait: got %0d waits (timeout %b) expected 3", nw, to);
        end
        @(negedge clk);
        n_cmp++;
        if (get_err(3) !== 1'b1) begin
            n_bad++; $display("FAIL bounds_err_set: got %b expected 1", get_err(3));
        end
        @(posedge clk); #1;
        exp_q.push_back(32'h78563412);
        access(3, 1'b1, 1'b0, 32'h0, '0, '0, nw, rd, to);
        e = exp_q.pop_front();
        n_cmp++;
        if (rd !== e) begin
            n_bad++; $display("FAIL bounds_mem_unchanged: got %h expected %h", rd, e);
        end
        exp_q.push_back(32'h0);
        access(3, 1'b1, 1'b0, 32'h40, '0, '0, nw, rd, to);
        e = exp_q.pop_front();
        n_cmp++;
        if (to !== 1'b0 || nw !== 3 || rd !== e) begin
            n_bad++; $display("FAIL bounds_read: got %h after %0d waits expected %h after 3", rd, nw, e);
        end
        rst3 = 1'b1;
        @(posedge clk); #1;
        rst3 = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (get_err(3) !== 1'b0 || get_rd(3) !== 32'h0) begin
            n_bad++; $display("FAIL bounds_reset_clear: got err %b data %h expected err 0 data 00000000", get_err(3), get_rd(3));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_access();
        int nw; word_t rd; bit to; word_t e;
        // reset in the 2nd cycle of a write
        drive(2, 1'b0, 1'b1, 32'hC, 32'hFFFFFFFF, 4'hF);
        @(negedge clk);
        n_cmp++;
        if (get_wait(2) !== 1'b1) begin
            n_bad++; $display("FAIL rmid_first_wait: got %b expected 1", get_wait(2));
        end
        @(posedge clk); #1;
        rst2 = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (get_wait(2) !== 1'b1) begin
            n_bad++; $display("FAIL rmid_reset_wait: got %b expected 1", get_wait(2));
        end
        @(posedge clk); #1;
        rst2 = 1'b0;
        drive(2, 1'b0, 1'b0, '0, '0, '0);
        exp_q.push_back(pre(3));
        access(2, 1'b1, 1'b0, 32'hC, '0, '0, nw, rd, to);
        e = exp_q.pop_front();
        n_cmp++;
        if (to !== 1'b0 || nw !== 2) begin
            n_bad++; $display("FAIL rmid_read_latency: got %0d waits (timeout %b) expected 2", nw, to);
        end
        n_cmp++;
        if (rd !== e) begin
            n_bad++; $display("FAIL rmid_word_unchanged: got %h expected %h", rd, e);
        end
        // reset in the cycle the write would have completed
        drive(2, 1'b0, 1'b1, 32'h10, 32'h0, 4'hF);
        repeat (2) begin
            @(negedge clk);
            @(posedge clk); #1;
        end
        rst2 = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (get_wait(2) !== 1'b1) begin
            n_bad++; $display("FAIL rlast_reset_wait: got %b expected 1", get_wait(2));
        end
        @(posedge clk); #1;
        rst2 = 1'b0;
        drive(2, 1'b0, 1'b0, '0, '0, '0);
        exp_q.push_back(pre(4));
        access(2, 1'b1, 1'b0, 32'h10, '0, '0, nw, rd, to);
        e = exp_q.pop_front();
        n_cmp++;
        if (to !== 1'b0 || nw !== 2 || rd !== e) begin
            n_bad++; $display("FAIL rlast_word_unchanged: got %h after %0d waits expected %h after 2", rd, nw, e);
        end
    endtask

    task automatic test_read_write_together();
        int nw; word_t rd; bit to; word_t e;
        @(negedge clk);
        n_cmp++;
        if (get_err(0) !== 1'b0) begin
            n_bad++; $display("FAIL rw_err_before: got %b expected 0", get_err(0));
        end
        @(posedge clk); #1;
        exp_q.push_back(32'h78563412);
        access(0, 1'b1, 1'b0, 32'h0, '0, '0, nw, rd, to);
        e = exp_q.pop_front();
        n_cmp++;
        if (rd !== e) begin
            n_bad++; $display("FAIL rw_prime_read: got %h expected %h", rd, e);
        end
        exp_q.push_back(32'h78563412);
        access(0, 1'b1, 1'b1, 32'h8, 32'h1, 4'hF, nw, rd, to);
        e = exp_q.pop_front();
        n_cmp++;
        if (to !== 1'b0 || rd !== e) begin
            n_bad++; $display("FAIL rw_readdata_held: got %h (timeout %b) expected %h", rd, to, e);
        end
        @(negedge clk);
        n_cmp++;
        if (get_err(0) !== 1'b1) begin
            n_bad++; $display("FAIL rw_err_set: got %b expected 1", get_err(0));
        end
        @(posedge clk); #1;
        exp_q.push_back(32'h1);
        access(0, 1'b1, 1'b0, 32'h8, '0, '0, nw, rd, to);
        e = exp_q.pop_front();
        n_cmp++;
        if (rd !== e) begin
            n_bad++; $display("FAIL rw_word_written: got %h expected %h", rd, e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_preload();
        test_wait_states();
        test_byte_enable();
        test_bounds();
        test_reset_mid_access();
        test_read_write_together();
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_bad++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
